zl_ts_packet_gen: RTL and testbench
===================================

// Module: zl_ts_packet_gen
// PURPOSE
// - Parametrised MPEG-TS packet source: emits 188-byte packets (0x47 sync, 4-byte header, 184-byte payload) on a byte-wide req/ack stream.
// - Drives data_in/data_in_req/data_in_ack of zl_dvb_s_core for on-chip BIST and for file-free simulation.
// - Adds a programmable PID, a continuity counter, four payload modes, inter-packet gaps, a finite packet count and a done flag.
// PARAMETERS
// - PID         13'h0100  PID carried in modes 0,1,3 (mode 2 forces 13'h1FFF)
// - N_PACKETS   0         packets to emit before done; 0 = unlimited
// - GAP_CYCLES  0         idle cycles (req=0) between packets; 0 = back-to-back
// - PRBS_SEED   15'h4A80  PRBS-15 seed, reloaded at reset and at every enable rise from IDLE
// PORTS
// - clk           in   1   clock
// - rst           in   1   synchronous reset, active-high
// - enable        in   1   run request; level-sensitive
// - mode          in   2   payload mode: 0 counter, 1 PRBS-15, 2 null packet, 3 constant 0x00
// - data_out      out  8   stream byte
// - data_out_req  out  1   byte valid
// - data_out_ack  in   1   consumer accept; a transfer occurs when req && ack
// - data_out_sop  out  1   high with the 0x47 sync byte
// - pkt_count     out  16  packets fully transferred; wraps at 2^16
// - done          out  1   N_PACKETS reached (sticky until rst)
// BEHAVIOUR
// - Reset: data_out=0, data_out_req=0, data_out_sop=0, pkt_count=0, done=0, CC=0.
//   Byte counter and counter-mode value = 0. PRBS = PRBS_SEED. State = IDLE.
// - FSM: IDLE -> HDR (enable=1) -> PAYLOAD (after header byte 3 is acked) -> GAP or HDR or DONE (after byte 187 is acked).
//   GAP -> HDR after GAP_CYCLES cycles.
//   HDR/GAP -> IDLE when enable=0 at a packet boundary; packets are never truncated.
// - Latency: enable sampled high in IDLE -> req=1 with 0x47 on the next cycle.
// - Header: B0 0x47; B1 {TEI=0, PUSI=0, PRIO=0, PID[12:8]}; B2 PID[7:0]; B3 {2'b00, AFC=2'b01, CC[3:0]}.
// - CC increments by 1 per packet, wrapping 15 -> 0.
// - mode is sampled at the start of each packet, in the cycle HDR is entered. Changes mid-packet take effect on the next packet.
// - Payload modes:
//   - mode 0: running byte counter, continuous across packets, wraps 0xFF -> 0x00.
//   - mode 1: PRBS-15, x^15+x^14+1. Eight successive output bits per byte, MSB first. Advances only on transfer.
//   - mode 2: null packet, PID 0x1FFF, payload all 0xFF.
//   - mode 3: payload all 0x00.
// - Handshake:
//   - While req && !ack, data_out and data_out_sop hold stable.
//   - Next byte is presented the cycle after an accepted transfer (1 byte/cycle when ack is held high).
//   - req never drops mid-packet.
// - pkt_count increments in the cycle byte 187 is transferred.
//   - If N_PACKETS>0 and pkt_count reaches N_PACKETS: state DONE, req=0, done=1 from the next cycle. Only rst leaves DONE.
// - Boundary cases:
//   - enable drop mid-packet: the packet completes.
//   - ack asserted while req=0: ignored.
//   - rst mid-packet: all state returns to reset values, and the next packet restarts at 0x47 with CC=0.
// - Width rules: all counters are unsigned modulo their width. The byte index is 8 bits and counts 0..187.
// STRUCTURE
// - Shared include zl_ts_defs.vh:
//   - TS_SYNC=8'h47, TS_PKT_LEN=188, TS_HDR_LEN=4, TS_NULL_PID=13'h1FFF.
//   - Mode encodings ZL_TS_MODE_*.
//   - FSM state encodings.
// - One sub-module, zl_prbs15_byte: 15-bit LFSR; step input advances 8 bits; combinational byte output; seed load.
// - Single always block for the FSM and counters; no other hierarchy.
// TESTING
// 1. mode=0, PID=0x100, ack=1 continuously -> first packet 47 01 00 10 00 01 .. B7.
//    Second packet 47 01 00 11 B8 .. with sop=1 exactly on each 0x47.
// 2. Same as 1 with random ack (≈50%) -> byte sequence identical to 1.
//    data_out stable during every stall; no drop or duplicate.
// 3. 17 packets, mode=3 -> B3 of packet 16 = 0x10 (CC wrapped).
//    pkt_count=17; payload all 0x00.
// 4. N_PACKETS=3, GAP_CYCLES=5 -> exactly 564 transfers and 5 idle cycles between packets.
//    done=1 the cycle after the last transfer; req stays 0 afterwards even with enable=1.
// 5. Null packets: mode=2 -> 47 1F FF 10 then 0xFF x184.
//    Mode switch: mode changed 0->2 at payload byte 50 -> rest of packet still counter; next packet is null.
// 6. mode=1 vs golden PRBS model seeded 0x4A80 -> all payload bytes match.
//    rst pulse at payload byte 100 -> restart 47 01 00 10 with PRBS reseeded.

Source files
------------

// File: rtl/zl_ts_packet_gen_pkg.sv
// Shared constants for the MPEG-TS packet source: packet geometry, payload mode
// encodings, FSM state encodings and a header-byte helper.
package zl_ts_packet_gen_pkg;

   localparam logic [7:0]  TS_SYNC     = 8'h47;
   localparam int unsigned TS_PKT_LEN  = 188;
   localparam int unsigned TS_HDR_LEN  = 4;
   localparam logic [12:0] TS_NULL_PID = 13'h1FFF;

   // Byte-index values at the end of the header and the end of the packet
   localparam logic [7:0] TS_HDR_LAST = 8'(TS_HDR_LEN - 1);
   localparam logic [7:0] TS_PKT_LAST = 8'(TS_PKT_LEN - 1);

   localparam logic [1:0] ZL_TS_MODE_CNT  = 2'd0;
   localparam logic [1:0] ZL_TS_MODE_PRBS = 2'd1;
   localparam logic [1:0] ZL_TS_MODE_NULL = 2'd2;
   localparam logic [1:0] ZL_TS_MODE_ZERO = 2'd3;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StHdr     = 3'd1;
   localparam logic [2:0] StPayload = 3'd2;
   localparam logic [2:0] StGap     = 3'd3;
   localparam logic [2:0] StDone    = 3'd4;

   // Header byte 0..3: sync, {TEI,PUSI,PRIO,PID[12:8]}, PID[7:0], {scrambling,AFC=01,CC}
   function automatic logic [7:0] ts_hdr_byte(input logic [1:0]  idx,
                                              input logic [12:0] pid,
                                              input logic [3:0]  cc);
      logic [7:0] b;
      case (idx)
         2'd0:    b = TS_SYNC;
         2'd1:    b = {3'b000, pid[12:8]};
         2'd2:    b = pid[7:0];
         default: b = {2'b00, 2'b01, cc};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/zl_prbs15_byte.sv
// PRBS-15 (x^15 + x^14 + 1) byte generator. state_q[14] is LFSR stage 1 and
// state_q[0] is stage 15; each output bit is stage14 ^ stage15 and is fed back
// into stage 1. data shows the next eight bits, MSB first; step consumes them.
module zl_prbs15_byte #(
   parameter logic [14:0] SEED = 15'h4A80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       step,
   output logic [7:0] data
);

   logic [14:0] state_q;
   logic [14:0] state_adv;

   // Unroll eight LFSR shifts to form the byte and the post-byte state
   always_comb begin
      state_adv = state_q;
      data      = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         data[i]   = state_adv[1] ^ state_adv[0];
         state_adv = {state_adv[1] ^ state_adv[0], state_adv[14:1]};
      end
   end

   // Seed on reset or load; otherwise advance one byte per step
   always_ff @(posedge clk) begin
      if (rst || load) begin
         state_q <= SEED;
      end else if (step) begin
         state_q <= state_adv;
      end
   end

endmodule

// File: rtl/zl_ts_packet_gen.sv
// MPEG-TS packet source on a byte-wide req/ack stream. Emits 188-byte packets
// with programmable PID, continuity counter, four payload modes, optional
// inter-packet gaps and an optional packet limit with a sticky done flag.
module zl_ts_packet_gen
   import zl_ts_packet_gen_pkg::*;
#(
   parameter logic [12:0] PID        = 13'h0100,
   parameter int unsigned N_PACKETS  = 0,
   parameter int unsigned GAP_CYCLES = 0,
   parameter logic [14:0] PRBS_SEED  = 15'h4A80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  mode,
   output logic [7:0]  data_out,
   output logic        data_out_req,
   input  logic        data_out_ack,
   output logic        data_out_sop,
   output logic [15:0] pkt_count,
   output logic        done
);

   localparam logic [15:0] N_LIMIT  = 16'(N_PACKETS);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

   logic [2:0]  state_q;
   logic [7:0]  byte_idx_q;
   logic [3:0]  cc_q;
   logic [7:0]  cnt_q;
   logic [1:0]  mode_q;
   logic [15:0] gap_cnt_q;

   logic        xfer;
   logic        hit_limit;
   logic [15:0] pkt_count_nxt;
   logic [12:0] pid_eff;
   logic [7:0]  prbs_byte;
   logic        prbs_load;
   logic        prbs_step;
   logic [7:0]  pay_byte;

   assign xfer          = data_out_req && data_out_ack;
   assign pkt_count_nxt = pkt_count + 16'd1;
   assign hit_limit     = (N_PACKETS != 0) && (pkt_count_nxt == N_LIMIT);
   assign pid_eff       = (mode_q == ZL_TS_MODE_NULL) ? TS_NULL_PID : PID;

   // PRBS reseeds whenever a run starts from idle; it advances each time a PRBS
   // payload byte is loaded into data_out, i.e. once per transferred byte
   assign prbs_load = (state_q == StIdle) && enable;
   assign prbs_step = xfer && (mode_q == ZL_TS_MODE_PRBS) &&
                      (((state_q == StHdr) && (byte_idx_q == TS_HDR_LAST)) ||
                       ((state_q == StPayload) && (byte_idx_q != TS_PKT_LAST)));

   zl_prbs15_byte #(
      .SEED (PRBS_SEED)
   ) u_prbs (
      .clk  (clk),
      .rst  (rst),
      .load (prbs_load),
      .step (prbs_step),
      .data (prbs_byte)
   );

   // Select the next payload byte for the mode latched at packet start
   always_comb begin
      pay_byte = 8'h00;
      case (mode_q)
         ZL_TS_MODE_CNT:  pay_byte = cnt_q;
         ZL_TS_MODE_PRBS: pay_byte = prbs_byte;
         ZL_TS_MODE_NULL: pay_byte = 8'hFF;
         default:         pay_byte = 8'h00;
      endcase
   end

   // Packet FSM, byte index, counters and registered stream outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         byte_idx_q   <= 8'd0;
         cc_q         <= 4'd0;
         cnt_q        <= 8'd0;
         mode_q       <= ZL_TS_MODE_CNT;
         gap_cnt_q    <= 16'd0;
         data_out     <= 8'h00;
         data_out_req <= 1'b0;
         data_out_sop <= 1'b0;
         pkt_count    <= 16'd0;
         done         <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (enable) begin
                  state_q      <= StHdr;
                  byte_idx_q   <= 8'd0;
                  data_out     <= TS_SYNC;
                  data_out_sop <= 1'b1;
                  data_out_req <= 1'b1;
                  mode_q       <= mode;
               end
            end
            StHdr: begin
               if (xfer) begin
                  byte_idx_q   <= byte_idx_q + 8'd1;
                  data_out_sop <= 1'b0;
                  if (byte_idx_q == TS_HDR_LAST) begin
                     state_q  <= StPayload;
                     data_out <= pay_byte;
                     if (mode_q == ZL_TS_MODE_CNT) cnt_q <= cnt_q + 8'd1;
                  end else begin
                     data_out <= ts_hdr_byte(byte_idx_q[1:0] + 2'd1, pid_eff, cc_q);
                  end
               end
            end
            StPayload: begin
               if (xfer) begin
                  if (byte_idx_q == TS_PKT_LAST) begin
                     pkt_count  <= pkt_count_nxt;
                     cc_q       <= cc_q + 4'd1;
                     byte_idx_q <= 8'd0;
                     if (hit_limit) begin
                        state_q      <= StDone;
                        data_out_req <= 1'b0;
                        done         <= 1'b1;
                     end else if (GAP_CYCLES != 0) begin
                        state_q      <= StGap;
                        data_out_req <= 1'b0;
                        gap_cnt_q    <= 16'd0;
                     end else if (enable) begin
                        state_q      <= StHdr;
                        data_out     <= TS_SYNC;
                        data_out_sop <= 1'b1;
                        mode_q       <= mode;
                     end else begin
                        state_q      <= StIdle;
                        data_out_req <= 1'b0;
                     end
                  end else begin
                     byte_idx_q <= byte_idx_q + 8'd1;
                     data_out   <= pay_byte;
                     if (mode_q == ZL_TS_MODE_CNT) cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q == GAP_LAST) begin
                  if (enable) begin
                     state_q      <= StHdr;
                     byte_idx_q   <= 8'd0;
                     data_out     <= TS_SYNC;
                     data_out_sop <= 1'b1;
                     data_out_req <= 1'b1;
                     mode_q       <= mode;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + 16'd1;
               end
            end
            StDone: begin
               data_out_req <= 1'b0;
            end
            default: begin
               state_q      <= StIdle;
               data_out_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zl_ts_packet_gen.sv
// Bench for zl_ts_packet_gen: table of first-packet vectors per mode, a
// packet-level reference model driven by random ack, and hand sequences for
// mode switch, CC wrap, reset mid-packet, enable drop and the packet limit.
module tb_zl_ts_packet_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, enable_a, ack_a, req_a, sop_a, done_a;
   logic [1:0]  mode_a;
   logic [7:0]  data_a;
   logic [15:0] pkt_count_a;

   logic        rst_b, enable_b, ack_b, req_b, sop_b, done_b;
   logic [1:0]  mode_b;
   logic [7:0]  data_b;
   logic [15:0] pkt_count_b;

   zl_ts_packet_gen u_dut_a (
      .clk          (clk),
      .rst          (rst_a),
      .enable       (enable_a),
      .mode         (mode_a),
      .data_out     (data_a),
      .data_out_req (req_a),
      .data_out_ack (ack_a),
      .data_out_sop (sop_a),
      .pkt_count    (pkt_count_a),
      .done         (done_a)
   );

   zl_ts_packet_gen #(
      .N_PACKETS  (3),
      .GAP_CYCLES (5)
   ) u_dut_b (
      .clk          (clk),
      .rst          (rst_b),
      .enable       (enable_b),
      .mode         (mode_b),
      .data_out     (data_b),
      .data_out_req (req_b),
      .data_out_ack (ack_b),
      .data_out_sop (sop_b),
      .pkt_count    (pkt_count_b),
      .done         (done_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (packet level) ----------------
   localparam logic [14:0] SEED = 15'h4A80;

   logic [7:0] exp_q[$];
   bit         prbs_q[$];     // last 15 sequence bits, oldest first
   logic [7:0] cap[$];
   logic [7:0] b3_log[$];
   int         m_cc, m_cnt, m_pkts, pos;
   logic       prev_req, prev_ack, prev_sop;
   logic [7:0] prev_data;
   bit         ack_rand;

   function automatic void prbs_reseed();
      logic [14:0] s;
      s = SEED;
      prbs_q.delete();
      for (int i = 0; i < 15; i++) prbs_q.push_back(s[i]);
   endfunction

   // Sequence recurrence b[n] = b[n-15] ^ b[n-14]; eight bits per byte, MSB first
   function automatic logic [7:0] prbs_next_byte();
      logic [7:0] v;
      bit b;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         b = prbs_q[0] ^ prbs_q[1];
         prbs_q.push_back(b);
         void'(prbs_q.pop_front());
         v = {v[6:0], b};
      end
      return v;
   endfunction

   function automatic void gen_packet(input logic [1:0] m);
      logic [12:0] pid;
      pid = (m == 2'd2) ? 13'h1FFF : 13'h0100;
      exp_q.push_back(8'h47);
      exp_q.push_back({3'b000, pid[12:8]});
      exp_q.push_back(pid[7:0]);
      exp_q.push_back(8'h10 | 8'(m_cc % 16));
      for (int i = 0; i < 184; i++) begin
         case (m)
            2'd0: begin exp_q.push_back(8'(m_cnt % 256)); m_cnt++; end
            2'd1: exp_q.push_back(prbs_next_byte());
            2'd2: exp_q.push_back(8'hFF);
            default: exp_q.push_back(8'h00);
         endcase
      end
      m_cc++;
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      cap.delete();
      b3_log.delete();
      m_cc = 0; m_cnt = 0; m_pkts = 0; pos = 0;
      prev_req = 1'b0; prev_ack = 1'b0; prev_sop = 1'b0; prev_data = 8'h00;
      prbs_reseed();
   endfunction

   // Called at the negedge with ack already set for the coming posedge
   task automatic monitor();
      logic [7:0] e;
      if (prev_req && !prev_ack)
         chk("stall_hold", 32'({req_a, sop_a, data_a}), 32'({1'b1, prev_sop, prev_data}));
      if (pos != 0) chk("req_mid_packet", 32'(req_a), 32'd1);
      if (req_a && ack_a) begin
         if (pos == 0) begin
            chk("pkt_count_at_sop", 32'(pkt_count_a), 32'(m_pkts % 65536));
            gen_packet(mode_a);
         end
         e = exp_q.pop_front();
         chk($sformatf("byte_p%0d_i%0d", m_pkts, pos), 32'(data_a), 32'(e));
         chk("sop_flag", 32'(sop_a), 32'(pos == 0));
         cap.push_back(data_a);
         if (pos == 3) b3_log.push_back(data_a);
         if (pos == 187) begin
            pos = 0;
            m_pkts++;
         end else begin
            pos++;
         end
      end
      prev_req  = req_a;
      prev_ack  = ack_a;
      prev_sop  = sop_a;
      prev_data = data_a;
   endtask

   task automatic tick();
      @(negedge clk);
      ack_a = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      monitor();
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      model_reset();
      tick();
      chk("rst_data", 32'(data_a), 32'd0);
      chk("rst_req", 32'(req_a), 32'd0);
      chk("rst_sop", 32'(sop_a), 32'd0);
      chk("rst_pkt_count", 32'(pkt_count_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      rst_a = 1'b0;
   endtask

   task automatic run_pkts(input int n, input int budget, input string name);
      int c;
      c = 0;
      while (m_pkts < n && c < budget) begin
         tick();
         c++;
      end
      chk(name, 32'(m_pkts >= n), 32'd1);
   endtask

   task automatic run_pos(input int p, input int budget, input string name);
      int c;
      c = 0;
      while (pos != p && c < budget) begin
         tick();
         c++;
      end
      chk(name, 32'(pos == p), 32'd1);
   endtask

   task automatic run_cap(input int n, input int budget, input string name);
      int c;
      c = 0;
      while (cap.size() < n && c < budget) begin
         tick();
         c++;
      end
      chk(name, 32'(cap.size() >= n), 32'd1);
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [7:0] b1, b2, b3, p0, p1;
   } vec_t;

   vec_t vecs[4];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int reqs, xfers, gap_run, since_last, c;
      bit seen_done;
      int gaps[$];

      rst_a = 1'b1; enable_a = 1'b0; ack_a = 1'b0; mode_a = 2'd0; ack_rand = 1'b0;
      rst_b = 1'b1; enable_b = 1'b0; ack_b = 1'b1; mode_b = 2'd0;
      model_reset();

      // First six bytes of the first packet after reset, per mode
      vecs[0] = '{2'd0, 8'h01, 8'h00, 8'h10, 8'h00, 8'h01};
      vecs[1] = '{2'd1, 8'h01, 8'h00, 8'h10, 8'h03, 8'hF6};
      vecs[2] = '{2'd2, 8'h1F, 8'hFF, 8'h10, 8'hFF, 8'hFF};
      vecs[3] = '{2'd3, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00};
      for (int v = 0; v < 4; v++) begin
         enable_a = 1'b0;
         ack_rand = 1'b0;
         reset_a();
         mode_a   = vecs[v].mode;
         enable_a = 1'b1;
         run_cap(6, 50, $sformatf("vec%0d_len", v));
         chk($sformatf("vec%0d_b0", v), 32'(cap[0]), 32'h47);
         chk($sformatf("vec%0d_b1", v), 32'(cap[1]), 32'(vecs[v].b1));
         chk($sformatf("vec%0d_b2", v), 32'(cap[2]), 32'(vecs[v].b2));
         chk($sformatf("vec%0d_b3", v), 32'(cap[3]), 32'(vecs[v].b3));
         chk($sformatf("vec%0d_p0", v), 32'(cap[4]), 32'(vecs[v].p0));
         chk($sformatf("vec%0d_p1", v), 32'(cap[5]), 32'(vecs[v].p1));
      end

      // Counter mode with random ack, then switch to null mid-payload
      enable_a = 1'b0;
      reset_a();
      mode_a   = 2'd0;
      ack_rand = 1'b1;
      enable_a = 1'b1;
      run_pkts(3, 4000, "cnt_three_pkts");
      run_pos(54, 1000, "cnt_reach_pay50");
      mode_a = 2'd2;
      run_pkts(5, 4000, "switch_pkts");
      chk("p0_last", 32'(cap[187]), 32'hB7);
      chk("p1_b3", 32'(cap[188 + 3]), 32'h11);
      chk("p1_p0", 32'(cap[188 + 4]), 32'hB8);
      chk("p3_last_still_cnt", 32'(cap[3 * 188 + 187]), 32'hDF);
      chk("p4_null_b1", 32'(cap[4 * 188 + 1]), 32'h1F);
      chk("p4_null_b2", 32'(cap[4 * 188 + 2]), 32'hFF);
      chk("p4_null_p0", 32'(cap[4 * 188 + 4]), 32'hFF);

      // Seventeen zero-payload packets: CC wraps
      enable_a = 1'b0;
      reset_a();
      mode_a   = 2'd3;
      enable_a = 1'b1;
      run_pkts(17, 14000, "zero_17_pkts");
      tick();
      chk("zero_pkt_count", 32'(pkt_count_a), 32'd17);
      chk("cc15_b3", 32'(b3_log[15]), 32'h1F);
      chk("cc_wrap_b3", 32'(b3_log[16]), 32'h10);

      // PRBS mode, then reset in the middle of a packet
      enable_a = 1'b0;
      reset_a();
      mode_a   = 2'd1;
      enable_a = 1'b1;
      run_pkts(2, 4000, "prbs_two_pkts");
      run_pos(104, 1000, "prbs_reach_pay100");
      reset_a();
      run_cap(6, 100, "prbs_restart_len");
      chk("restart_b0", 32'(cap[0]), 32'h47);
      chk("restart_b1", 32'(cap[1]), 32'h01);
      chk("restart_b3", 32'(cap[3]), 32'h10);
      chk("restart_p0", 32'(cap[4]), 32'h03);
      chk("restart_p1", 32'(cap[5]), 32'hF6);
      run_pkts(1, 2000, "prbs_after_rst");

      // Enable dropped mid-packet: packet completes, then the stream stops
      enable_a = 1'b0;
      reset_a();
      mode_a   = 2'd0;
      enable_a = 1'b1;
      run_pos(50, 1000, "drop_reach");
      enable_a = 1'b0;
      run_pkts(1, 2000, "drop_completes");
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         reqs += int'(req_a);
      end
      chk("drop_idle_req", 32'(reqs), 32'd0);

      // Limited instance: 3 packets, 5-cycle gaps, done
      tick();
      tick();
      rst_b    = 1'b0;
      enable_b = 1'b1;
      xfers = 0; gap_run = 0; since_last = 0; seen_done = 1'b0; c = 0;
      while (c < 3000) begin
         tick();
         c++;
         if (done_b) begin
            chk("done_latency", 32'(since_last), 32'd1);
            seen_done = 1'b1;
            break;
         end
         if (req_b) begin
            if (gap_run > 0) gaps.push_back(gap_run);
            gap_run = 0;
         end else if (xfers > 0) begin
            gap_run++;
         end
         if (req_b && ack_b) begin
            xfers++;
            since_last = 0;
         end
         since_last++;
      end
      chk("lim_done_seen", 32'(seen_done), 32'd1);
      chk("lim_xfers", 32'(xfers), 32'd564);
      chk("lim_gap_count", 32'(gaps.size()), 32'd2);
      chk("lim_gap0", 32'(gaps[0]), 32'd5);
      chk("lim_gap1", 32'(gaps[1]), 32'd5);
      chk("lim_pkt_count", 32'(pkt_count_b), 32'd3);
      reqs = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         reqs += int'(req_b);
      end
      chk("lim_req_after_done", 32'(reqs), 32'd0);
      chk("lim_done_sticky", 32'(done_b), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
